// File: rtl/mult_share_ctrl.sv
// Sequencer and 2-way round-robin arbiter for a shared shift/add multiplier datapath.
// Optional iteration watchdog is compiled in with `define MULT_WATCHDOG_EN.
module mult_share_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             rbzero,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic             la,
  output logic             lb,
  output logic             clrp,
  output logic             lp,
  output logic             decb,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, FIN} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   grant;
  logic   grant_id;
  logic   limit;

`ifdef MULT_WATCHDOG_EN
  localparam logic [WIDTH-1:0] MAX_ITER_W = WIDTH'(MAX_ITER);
  logic [WIDTH-1:0] iter;

  assign limit = (iter == MAX_ITER_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
      err  <= 1'b0;
    end else begin
      if (state == LOAD)
        iter <= '0;
      else if (lp)
        iter <= iter + 1'b1;
      if (state == ACCUM && !rbzero && limit)
        err <= 1'b1;
    end
  end
`else
  localparam int unused_max_iter = MAX_ITER;
  assign limit = 1'b0;
  assign err   = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    la        = 1'b0;
    lb        = 1'b0;
    clrp      = 1'b0;
    lp        = 1'b0;
    decb      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          // On a tie the requester that was not served last wins.
          grant_id  = (req0 && req1) ? ~last : req1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        la        = 1'b1;
        lb        = 1'b1;
        clrp      = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        if (rbzero || limit) begin
          state_nxt = FIN;
        end else begin
          lp   = 1'b1;
          decb = 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      opa   <= '0;
      opb   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt0 <= ~grant_id;
        gnt1 <= grant_id;
        opa  <= grant_id ? a1 : a0;
        opb  <= grant_id ? b1 : b0;
        last <= grant_id;
      end else if (state == FIN) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
      end
      // DONE is registered on entry to FIN so it lines up with the FIN cycle.
      done0 <= (state == ACCUM) && (state_nxt == FIN) && gnt0;
      done1 <= (state == ACCUM) && (state_nxt == FIN) && gnt1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencer and 2-way round-robin arbiter for the shared shift/add multiplier datapath (A/B/P registers, B down-counter, RBZERO flag).
- Two requesters each present operands plus REQ.
- The block grants one, steers its operands onto the datapath inputs, drives the load/accumulate strobes until B reaches zero, then pulses that requester's DONE.
- It sits between the requesting units and the datapath; the datapath itself is unchanged.

Parameters:
- WIDTH, 8, operand width of A and B.
- MAX_ITER, 255, accumulate-cycle limit. Used only when the watchdog is compiled in.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ0  in  1  requester 0 request. Level; held until DONE0.
- A0  in  WIDTH  requester 0 multiplicand.
- B0  in  WIDTH  requester 0 multiplier.
- REQ1  in  1  requester 1 request.
- A1  in  WIDTH  requester 1 multiplicand.
- B1  in  WIDTH  requester 1 multiplier.
- RBZERO  in  1  datapath flag, B register == 0. Combinational from the datapath.
- OPA  out  WIDTH  registered multiplicand to datapath A input.
- OPB  out  WIDTH  registered multiplier to datapath B input.
- LA  out  1  load A register.
- LB  out  1  load B register.
- CLRP  out  1  clear P register.
- LP  out  1  load P <= P + A.
- DECB  out  1  decrement B.
- GNT0  out  1  requester 0 owns the datapath.
- GNT1  out  1  requester 1 owns the datapath.
- DONE0  out  1  one-cycle pulse, requester 0 product valid on P.
- DONE1  out  1  one-cycle pulse, requester 1 product valid on P.
- BUSY  out  1  state != IDLE.
- ERR  out  1  sticky watchdog error. Tied 0 without the macro.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE, LAST=1.
  - OPA=OPB=0; GNT0/1=0; DONE0/1=0; ERR=0.
  - All strobes 0 immediately, mid-operation included. No completion pulse for an aborted job.
- States: IDLE, LOAD, ACCUM, FIN.
- Strobes are decoded from the registered state:
  - LA=LB=CLRP=1 only in LOAD.
  - LP=DECB=1 only in ACCUM while RBZERO=0, gated combinationally.
- IDLE:
  - Strobes 0.
  - Only REQ0: grant 0. Only REQ1: grant 1.
  - Both: grant the index != LAST.
  - On grant, at that edge: GNTx<=1, OPA/OPB<=Ax/Bx, LAST<=x, next state LOAD.
  - No request: stay in IDLE.
- LOAD:
  - One cycle. The datapath captures OPA/OPB and clears P at the closing edge. Next state ACCUM.
- ACCUM:
  - RBZERO=0: LP/DECB high, stay in ACCUM.
  - RBZERO=1: strobes low, next state FIN.
  - Exactly B accumulate cycles, then one terminating cycle.
- FIN:
  - One cycle. DONEx=1 for the granted x (registered on entry); GNTx stays 1.
  - Next edge: GNTx<=0, DONEx<=0, state IDLE.
- Latency, REQ sampled at edge E0:
  - GNT after E0; LOAD during cycle 1.
  - ACCUM during cycles 2..B+2.
  - DONE during cycle B+3.
  - The next grant is possible at edge B+4.
- Operands are captured only at grant. Changes to Ax/Bx or REQx afterwards do not affect the running job.
- If REQx drops mid-job, the job still completes and DONEx still pulses.
- If REQx stays high after DONEx, it is treated as a new request. Round-robin favours the other requester on a tie.
- B=0: zero LP/DECB cycles; P=0 at DONE.
- OPA/OPB hold their last value between jobs.
- Simultaneous REQ rise in the same cycle as FIN: that request is ignored until IDLE and arbitrated at the next edge.

Optional Feature:
- Macro: MULT_WATCHDOG_EN.
- Defined:
  - A WIDTH-bit iteration counter clears in LOAD and increments per LP cycle.
  - If it reaches MAX_ITER while in ACCUM with RBZERO=0: strobes drop, ERR<=1 (sticky until reset), state FIN, DONEx pulses normally.
- Undefined: no counter, ERR constant 0, ACCUM is unbounded.

Test Plan:
- REQ0=1, A0=5, B0=3, bench datapath model → GNT0 at cycle 1; LA/LB/CLRP cycle 1; LP/DECB cycles 2-4; DONE0 cycle 6; P=15; BUSY high cycles 1-6.
- REQ1=1, A1=9, B1=0 → zero LP cycles; DONE1 at cycle 3; P=0.
- REQ0 and REQ1 rise together after reset (A0=2,B0=2; A1=3,B1=4), both held high → job 0 first (P=4, DONE0), then job 1 (P=12, DONE1), then job 0 again; strict alternation.
- RST_N low during ACCUM of A0=7,B0=10 → all outputs 0 without waiting for an edge; no DONE; a fresh REQ0 with A0=7,B0=2 yields P=14.
- Change A0/B0 during ACCUM (A0=3,B0=3 captured, then set to 0) → P=9.
- MULT_WATCHDOG_EN, MAX_ITER=4, RBZERO forced 0 → exactly 4 LP cycles, then ERR=1 and DONE0 pulse; ERR stays 1 through a following normal job until RST_N.
